// File: rtl/fa_mon_pkg.sv
// -----------------------------------------------------------------------------
// fa_mon_pkg
// Shared definitions for the full-adder Trojan monitor:
//   - mon_state_t : monitor FSM encoding (MON_MONITOR / MON_SUSPECT / MON_ALERT)
//   - fa_golden() : reference full adder, returns {sum, cout}
// -----------------------------------------------------------------------------
package fa_mon_pkg;

   typedef enum logic [1:0] {
      MON_MONITOR = 2'd0,
      MON_SUSPECT = 2'd1,
      MON_ALERT   = 2'd2
   } mon_state_t;

   // Golden full adder; result packed as {sum, cout}.
   function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
      logic w_sum;
      logic w_cout;
      w_sum  = a ^ b ^ cin;
      w_cout = (a & b) | (a & cin) | (b & cin);
      return {w_sum, w_cout};
   endfunction

endpackage

// File: rtl/fa_trojan_monitor_if.sv
// -----------------------------------------------------------------------------
// fa_trojan_monitor_if
// Bundle between the observed adder (plus its soft clear) and the monitor.
//   in_valid, a, b, cin : adder input vector tapped at the DUT
//   sum, cout           : DUT registered outputs
//   clear               : synchronous soft clear
//   mismatch, run_len, err_cnt, suspect, alert, state, log_vec : monitor status
// Modports: master (drives the tapped signals, reads status), slave (monitor).
// -----------------------------------------------------------------------------
interface fa_trojan_monitor_if #(
   parameter int CNT_W = 8
) ();
   logic             in_valid;
   logic             a;
   logic             b;
   logic             cin;
   logic             sum;
   logic             cout;
   logic             clear;
   logic             mismatch;
   logic [CNT_W-1:0] run_len;
   logic [CNT_W-1:0] err_cnt;
   logic             suspect;
   logic             alert;
   logic [1:0]       state;
   logic [4:0]       log_vec;

   modport master (
      output in_valid, a, b, cin, sum, cout, clear,
      input  mismatch, run_len, err_cnt, suspect, alert, state, log_vec
   );

   modport slave (
      input  in_valid, a, b, cin, sum, cout, clear,
      output mismatch, run_len, err_cnt, suspect, alert, state, log_vec
   );
endinterface

// File: rtl/fa_exp_pipe.sv
// -----------------------------------------------------------------------------
// fa_exp_pipe
// LATENCY-deep delay line of {valid, vector, expected {sum,cout}} so that the
// golden expectation lines up with the adder's registered output.
// Ports:
//   clk, rst_n (sync, active-low), i_clear (soft clear of the whole line)
//   i_valid, i_vec[2:0] = {a,b,cin} : vector entering stage 0
//   o_valid, o_vec, o_exp           : stage LATENCY-1 contents
// -----------------------------------------------------------------------------
module fa_exp_pipe
   import fa_mon_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic       i_valid,
   input  logic [2:0] i_vec,
   output logic       o_valid,
   output logic [2:0] o_vec,
   output logic [1:0] o_exp
);
   logic       r_vld [LATENCY];
   logic [2:0] r_vec [LATENCY];
   logic [1:0] r_exp [LATENCY];

   // Load stage 0 every cycle and shift unconditionally; valid rides with data.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i] <= 1'b0;
            r_vec[i] <= 3'b000;
            r_exp[i] <= 2'b00;
         end
      end else begin
         r_vld[0] <= i_valid;
         r_vec[0] <= i_vec;
         r_exp[0] <= fa_golden(i_vec[2], i_vec[1], i_vec[0]);
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_vec[i] <= r_vec[i-1];
            r_exp[i] <= r_exp[i-1];
         end
      end
   end

   assign o_valid = r_vld[LATENCY-1];
   assign o_vec   = r_vec[LATENCY-1];
   assign o_exp   = r_exp[LATENCY-1];
endmodule

// File: rtl/fa_trojan_monitor.sv
// -----------------------------------------------------------------------------
// fa_trojan_monitor
// Runtime checker for a registered full adder. Compares the adder outputs with
// a delayed golden expectation, tracks runs of identical valid vectors (a
// typical Trojan trigger) and raises a sticky alert when a long run is followed
// by wrong outputs or when errors accumulate.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fa_trojan_monitor_if.slave (tapped vector, DUT outputs, clear,
//           mismatch/run_len/err_cnt/suspect/alert/state/log_vec status)
// Build option: define FA_MON_LOG_EN to capture the first failing
// {a,b,cin,sum,cout} into log_vec; otherwise log_vec is tied to zero.
// -----------------------------------------------------------------------------
module fa_trojan_monitor
   import fa_mon_pkg::*;
#(
   parameter int LATENCY    = 1,
   parameter int RUN_THRESH = 6,
   parameter int WINDOW     = 8,
   parameter int ERR_THRESH = 2,
   parameter int CNT_W      = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   fa_trojan_monitor_if.slave  bus
);
   localparam int               WIN_W    = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0] RUN_TH_C = CNT_W'(RUN_THRESH);
   localparam logic [CNT_W-1:0] ERR_TH_C = CNT_W'(ERR_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);

   logic [2:0]       w_vec;
   logic             w_pv;
   logic [2:0]       w_pvec;
   logic [1:0]       w_pexp;
   logic             w_rst;
   logic             w_cmp_fail;
   logic [CNT_W-1:0] w_err_nxt;
   logic [CNT_W-1:0] w_run_nxt;
   logic             w_trigger;
   logic             w_err_hit;

   logic             r_mismatch;
   logic [CNT_W-1:0] r_run;
   logic [CNT_W-1:0] r_err;
   logic [2:0]       r_prev_vec;
   logic             r_have_prev;
   mon_state_t       r_state;
   logic [WIN_W-1:0] r_win;
   logic             r_suspect;
   logic             r_alert;

   assign w_vec = {bus.a, bus.b, bus.cin};
   assign w_rst = !rst_n || bus.clear;

   fa_exp_pipe #(.LATENCY(LATENCY)) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (bus.clear),
      .i_valid (bus.in_valid),
      .i_vec   (w_vec),
      .o_valid (w_pv),
      .o_vec   (w_pvec),
      .o_exp   (w_pexp)
   );

   assign w_cmp_fail = w_pv && ({bus.sum, bus.cout} != w_pexp);

   // Next error count, saturating.
   always_comb begin
      w_err_nxt = r_err;
      if (w_cmp_fail && (r_err != CNT_MAX)) begin
         w_err_nxt = r_err + CNT_W'(1);
      end else begin
         w_err_nxt = r_err;
      end
   end

   // Next run length: extend on a repeat, restart at 1 on a new vector, hold on idle.
   always_comb begin
      w_run_nxt = r_run;
      if (bus.in_valid) begin
         if (r_have_prev && (w_vec == r_prev_vec)) begin
            w_run_nxt = (r_run == CNT_MAX) ? r_run : (r_run + CNT_W'(1));
         end else begin
            w_run_nxt = CNT_W'(1);
         end
      end else begin
         w_run_nxt = r_run;
      end
   end

   // A valid vector keeping the run at/above threshold both arms and re-arms SUSPECT.
   assign w_trigger = bus.in_valid && (w_run_nxt >= RUN_TH_C);
   assign w_err_hit = (w_err_nxt >= ERR_TH_C);

   // Counters, mismatch pulse and run history.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_mismatch  <= 1'b0;
         r_run       <= '0;
         r_err       <= '0;
         r_prev_vec  <= 3'b000;
         r_have_prev <= 1'b0;
      end else begin
         r_mismatch <= w_cmp_fail;
         r_run      <= w_run_nxt;
         r_err      <= w_err_nxt;
         if (bus.in_valid) begin
            r_prev_vec  <= w_vec;
            r_have_prev <= 1'b1;
         end else begin
            r_prev_vec  <= r_prev_vec;
            r_have_prev <= r_have_prev;
         end
      end
   end

   // Monitor FSM with window counter and registered suspect/alert flags.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state   <= MON_MONITOR;
         r_win     <= '0;
         r_suspect <= 1'b0;
         r_alert   <= 1'b0;
      end else if (w_err_hit) begin
         r_state   <= MON_ALERT;
         r_win     <= '0;
         r_suspect <= 1'b0;
         r_alert   <= 1'b1;
      end else begin
         case (r_state)
            MON_MONITOR: begin
               if (w_trigger) begin
                  r_state   <= MON_SUSPECT;
                  r_win     <= WIN_LOAD;
                  r_suspect <= 1'b1;
               end else begin
                  r_state   <= MON_MONITOR;
                  r_win     <= '0;
                  r_suspect <= 1'b0;
               end
               r_alert <= 1'b0;
            end
            MON_SUSPECT: begin
               if (w_cmp_fail) begin
                  r_state   <= MON_ALERT;
                  r_win     <= '0;
                  r_suspect <= 1'b0;
                  r_alert   <= 1'b1;
               end else if (w_trigger) begin
                  r_state   <= MON_SUSPECT;
                  r_win     <= WIN_LOAD;
                  r_suspect <= 1'b1;
                  r_alert   <= 1'b0;
               end else if (r_win <= WIN_W'(1)) begin
                  // Last cycle of the window passed quietly.
                  r_state   <= MON_MONITOR;
                  r_win     <= '0;
                  r_suspect <= 1'b0;
                  r_alert   <= 1'b0;
               end else begin
                  r_state   <= MON_SUSPECT;
                  r_win     <= r_win - WIN_W'(1);
                  r_suspect <= 1'b1;
                  r_alert   <= 1'b0;
               end
            end
            MON_ALERT: begin
               r_state   <= MON_ALERT;
               r_win     <= '0;
               r_suspect <= 1'b0;
               r_alert   <= 1'b1;
            end
            default: begin
               // Unreachable encoding: fail safe into ALERT.
               r_state   <= MON_ALERT;
               r_win     <= '0;
               r_suspect <= 1'b0;
               r_alert   <= 1'b1;
            end
         endcase
      end
   end

`ifdef FA_MON_LOG_EN
   logic       r_logged;
   logic [4:0] r_log;

   // Capture the first failing vector and observed outputs; hold until clear/reset.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_logged <= 1'b0;
         r_log    <= 5'b00000;
      end else if (w_cmp_fail && !r_logged) begin
         r_logged <= 1'b1;
         r_log    <= {w_pvec, bus.sum, bus.cout};
      end else begin
         r_logged <= r_logged;
         r_log    <= r_log;
      end
   end

   assign bus.log_vec = r_log;
`else
   logic [2:0] w_unused_pvec;
   assign w_unused_pvec = w_pvec;
   assign bus.log_vec   = 5'b00000;
`endif

   assign bus.mismatch = r_mismatch;
   assign bus.run_len  = r_run;
   assign bus.err_cnt  = r_err;
   assign bus.suspect  = r_suspect;
   assign bus.alert    = r_alert;
   assign bus.state    = r_state;
endmodule

// File: tb/tb_fa_trojan_monitor.sv
// -----------------------------------------------------------------------------
// tb_fa_trojan_monitor
// Bench for fa_trojan_monitor (default parameters). A registered adder model
// drives sum/cout from the previous cycle's vector, optionally corrupted.
// Each driven cycle pushes the expected monitor outputs to a queue; after the
// clock edge the entry is popped and compared with the DUT.
// -----------------------------------------------------------------------------
module tb_fa_trojan_monitor;
   typedef struct packed {
      logic       mis;
      logic [7:0] run;
      logic [7:0] err;
      logic       sus;
      logic       al;
      logic [1:0] st;
      logic [4:0] lg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fa_trojan_monitor_if #(.CNT_W(8)) bus ();

   fa_trojan_monitor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   // Stimulus/adder-model state
   logic       rst_v  = 1'b0;
   logic       tro    = 1'b0;
   logic [2:0] ad_vec = 3'b000;

   // Reference model state
   int         m_state = 0;
   int         m_win   = 0;
   int         m_run   = 0;
   int         m_err   = 0;
   logic       m_mis   = 1'b0;
   logic [2:0] m_prev  = 3'b000;
   logic       m_have  = 1'b0;
   logic       m_pv    = 1'b0;
   logic [2:0] m_pvec  = 3'b000;
   logic [1:0] m_pexp  = 2'b00;
   logic       m_logd  = 1'b0;
   logic [4:0] m_log   = 5'b00000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Arithmetic form of the adder, independent of the xor/majority form.
   function automatic logic [1:0] ref_add(input logic [2:0] v);
      int t;
      t = int'(v[2]) + int'(v[1]) + int'(v[0]);
      return {t[0], (t >= 2)};
   endfunction

   task automatic model_edge(input logic iv, input logic [2:0] v, input logic s,
                             input logic c, input logic clr);
      logic fail;
      logic trig;
      if (!rst_v || clr) begin
         m_state = 0; m_win = 0; m_run = 0; m_err = 0; m_mis = 1'b0;
         m_prev = 3'b000; m_have = 1'b0; m_pv = 1'b0; m_pvec = 3'b000;
         m_pexp = 2'b00; m_logd = 1'b0; m_log = 5'b00000;
      end else begin
         fail = m_pv && ({s, c} != m_pexp);
         m_mis = fail;
         if (fail && m_err < 255) m_err++;
         if (fail && !m_logd) begin
            m_logd = 1'b1;
            m_log  = {m_pvec, s, c};
         end
         if (iv) begin
            if (m_have && v == m_prev) begin
               if (m_run < 255) m_run++;
            end else begin
               m_run = 1;
            end
            m_prev = v;
            m_have = 1'b1;
         end
         trig = iv && (m_run >= 6);
         if (m_err >= 2) begin
            m_state = 2;
         end else if (m_state == 0) begin
            if (trig) begin m_state = 1; m_win = 8; end
         end else if (m_state == 1) begin
            if (fail) m_state = 2;
            else if (trig) m_win = 8;
            else if (m_win == 1) m_state = 0;
            else m_win--;
         end
         m_pv   = iv;
         m_pvec = v;
         m_pexp = ref_add(v);
      end
   endtask

   task automatic step(input logic iv, input logic [2:0] v, input logic clr, input logic bad);
      exp_t       e;
      logic [1:0] o;
      @(negedge clk);
      o = ref_add(ad_vec);
      if (tro) o = 2'b00;
      if (bad) o[0] = ~o[0];
      ad_vec       = v;
      rst_n        = rst_v;
      bus.in_valid = iv;
      bus.a        = v[2];
      bus.b        = v[1];
      bus.cin      = v[0];
      bus.sum      = o[1];
      bus.cout     = o[0];
      bus.clear    = clr;
      model_edge(iv, v, o[1], o[0], clr);
      e.mis = m_mis;
      e.run = 8'(m_run);
      e.err = 8'(m_err);
      e.sus = (m_state == 1);
      e.al  = (m_state == 2);
      e.st  = 2'(m_state);
`ifdef FA_MON_LOG_EN
      e.lg  = m_log;
`else
      e.lg  = 5'b00000;
`endif
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("mismatch", 32'(bus.mismatch), 32'(e.mis));
      chk("run_len",  32'(bus.run_len),  32'(e.run));
      chk("err_cnt",  32'(bus.err_cnt),  32'(e.err));
      chk("suspect",  32'(bus.suspect),  32'(e.sus));
      chk("alert",    32'(bus.alert),    32'(e.al));
      chk("state",    32'(bus.state),    32'(e.st));
      chk("log_vec",  32'(bus.log_vec),  32'(e.lg));
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0; bus.cin = 1'b0;
      bus.sum = 1'b0; bus.cout = 1'b0; bus.clear = 1'b0;

      // Reset with random inputs
      rst_v = 1'b0;
      for (int i = 0; i < 2; i++) step(1'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_alert", 32'(bus.alert), 32'd0);

      // All eight vectors with a correct adder
      rst_v = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 1'b0);
      chk("clean_err", 32'(bus.err_cnt), 32'd0);

      // Trigger run, then window expiry with correct outputs
      for (int i = 0; i < 6; i++) step(1'b1, 3'b101, 1'b0, 1'b0);
      chk("sus_run", 32'(bus.run_len), 32'd6);
      chk("sus_state", 32'(bus.state), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 3'b110 : 3'b010, 1'b0, 1'b0);
      chk("timeout_state", 32'(bus.state), 32'd0);
      chk("timeout_alert", 32'(bus.alert), 32'd0);

      // Trojan: after trigger, adder forces sum=cout=0
      for (int i = 0; i < 6; i++) step(1'b1, 3'b101, 1'b0, 1'b0);
      tro = 1'b1;
      step(1'b1, 3'b011, 1'b0, 1'b0);
      chk("troj_mis", 32'(bus.mismatch), 32'd1);
      chk("troj_state", 32'(bus.state), 32'd2);
`ifdef FA_MON_LOG_EN
      chk("troj_log", 32'(bus.log_vec), 32'b10100);
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 3'(i + 1), 1'b0, 1'b0);
      chk("troj_hold", 32'(bus.alert), 32'd1);

      // Clear coincides with a mismatching compare in ALERT
      step(1'b1, 3'b111, 1'b1, 1'b0);
      chk("clr_state", 32'(bus.state), 32'd0);
      chk("clr_err", 32'(bus.err_cnt), 32'd0);
      chk("clr_run", 32'(bus.run_len), 32'd0);
      chk("clr_mis", 32'(bus.mismatch), 32'd0);
      tro = 1'b0;
      step(1'b0, 3'b000, 1'b0, 1'b0);

      // Error threshold from MONITOR: 000 reported with cout=1 twice
      step(1'b1, 3'b000, 1'b0, 1'b0);
      step(1'b1, 3'b011, 1'b0, 1'b1);
      chk("err1_state", 32'(bus.state), 32'd0);
      step(1'b1, 3'b110, 1'b0, 1'b0);
      step(1'b1, 3'b000, 1'b0, 1'b0);
      step(1'b1, 3'b011, 1'b0, 1'b1);
      chk("err2_cnt", 32'(bus.err_cnt), 32'd2);
      chk("err2_alert", 32'(bus.alert), 32'd1);
      step(1'b0, 3'b000, 1'b1, 1'b0);

      // Run with idle gaps, then reset mid-SUSPECT
      for (int i = 0; i < 5; i++) step(i % 2 == 0, 3'b101, 1'b0, 1'b0);
      chk("gap_run", 32'(bus.run_len), 32'd3);
      for (int i = 0; i < 6; i++) step(i % 2 == 1, 3'b101, 1'b0, 1'b0);
      chk("gap_sus", 32'(bus.state), 32'd1);
      rst_v = 1'b0;
      step(1'b1, 3'b101, 1'b0, 1'b0);
      chk("rst_mid", 32'(bus.state), 32'd0);
      rst_v = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 3'(i * 3), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
